// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: writeback destination select,
// writeback data select, and the architecturally fixed register indices.
package mips_pkg;

    // wb_reg_dst encodings
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;
    localparam logic [1:0] REGDST_RSVD = 2'b11;

    // wb_mem_to_reg encodings
    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
    localparam logic [1:0] MEMTOREG_LINK = 2'b10;
    localparam logic [1:0] MEMTOREG_RSVD = 2'b11;

    // Architectural register indices
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one write port, two combinational read
// ports and a debug read port. Register 0 is hardwired to zero on every
// read port; the whole array clears asynchronously on active-low reset.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREG];

    // Storage: async clear, single write per edge, index 0 never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != ZERO_IDX)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: address 0 reads zero regardless of array contents
    always_comb begin
        rdata1_o   = (raddr1_i   == ZERO_IDX) ? '0 : regs_q[raddr1_i];
        rdata2_o   = (raddr2_i   == ZERO_IDX) ? '0 : regs_q[raddr2_i];
        dbg_data_o = (dbg_addr_i == ZERO_IDX) ? '0 : regs_q[dbg_addr_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus register file. Picks the destination register and
// writeback data from the MEM/WB fields, commits on the rising clk edge,
// exports the effective write to the forwarding unit, and optionally lets
// the ID-stage read ports see the write in the same cycle.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wb_alu_out,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_link_pc,
    input  logic [ADDR_W-1:0] wb_rt,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [1:0]        wb_reg_dst,
    input  logic [1:0]        wb_mem_to_reg,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              fwd_wen,
    output logic [ADDR_W-1:0] fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0] dest_sel;
    logic              dest_valid;
    logic [DATA_W-1:0] data_sel;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;

    // Destination mux; the reserved encoding names no register
    always_comb begin
        dest_sel   = '0;
        dest_valid = 1'b1;
        case (wb_reg_dst)
            REGDST_RT:   dest_sel = wb_rt;
            REGDST_RD:   dest_sel = wb_rd;
            REGDST_LINK: dest_sel = LINK_IDX;
            default:     dest_valid = 1'b0;
        endcase
    end

    // Data mux; the reserved encoding falls back to the ALU result
    always_comb begin
        data_sel = wb_alu_out;
        case (wb_mem_to_reg)
            MEMTOREG_MEM:  data_sel = wb_mem_data;
            MEMTOREG_LINK: data_sel = wb_link_pc;
            default:       data_sel = wb_alu_out;
        endcase
    end

    // Effective write: suppressed for bubbles, reserved dest, $0 and reset
    always_comb begin
        fwd_wen   = wb_reg_write & dest_valid & (dest_sel != ZERO_IDX) & reset;
        fwd_waddr = fwd_wen ? dest_sel : '0;
        fwd_wdata = data_sel;
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk        (clk),
        .reset      (reset),
        .we_i       (fwd_wen),
        .waddr_i    (fwd_waddr),
        .wdata_i    (fwd_wdata),
        .raddr1_i   (ra1),
        .raddr2_i   (ra2),
        .rdata1_o   (rf_rd1),
        .rdata2_o   (rf_rd2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Write-through bypass; fwd_wen already excludes $0 so r0 stays zero
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        if (BYPASS && fwd_wen && (ra1 == fwd_waddr)) rd1 = fwd_wdata;
        if (BYPASS && fwd_wen && (ra2 == fwd_waddr)) rd2 = fwd_wdata;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing and a non-bypassing instance share the
// same stimulus and are checked against an array model of the registers.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] wb_alu_out, wb_mem_data, wb_link_pc;
    logic [4:0]  wb_rt, wb_rd;
    logic [1:0]  wb_reg_dst, wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  ra1, ra2, dbg_addr;
    logic [31:0] rd1, rd2, fwd_wdata, dbg_data;
    logic        fwd_wen;
    logic [4:0]  fwd_waddr;
    logic [31:0] nb_rd1, nb_rd2, nb_fwd_wdata, nb_dbg_data;
    logic        nb_fwd_wen;
    logic [4:0]  nb_fwd_waddr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_link_pc(wb_link_pc),
        .wb_rt(wb_rt), .wb_rd(wb_rd), .wb_reg_dst(wb_reg_dst),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .fwd_wen(fwd_wen), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_link_pc(wb_link_pc),
        .wb_rt(wb_rt), .wb_rd(wb_rd), .wb_reg_dst(wb_reg_dst),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .fwd_wen(nb_fwd_wen), .fwd_waddr(nb_fwd_waddr), .fwd_wdata(nb_fwd_wdata),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [4:0] m_dest();
        case (wb_reg_dst)
            2'b00:   return wb_rt;
            2'b01:   return wb_rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic m_wen();
        return wb_reg_write && (wb_reg_dst != 2'b11) && (m_dest() != 5'd0) && reset;
    endfunction

    function automatic logic [31:0] m_data();
        case (wb_mem_to_reg)
            2'b01:   return wb_mem_data;
            2'b10:   return wb_link_pc;
            default: return wb_alu_out;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && m_wen() && (a == m_dest())) return m_data();
        return mdl[a];
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_wb(input logic [1:0] dst, input logic [1:0] m2r,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [31:0] link, input logic we);
        wb_reg_dst = dst; wb_mem_to_reg = m2r; wb_rt = rt; wb_rd = rd;
        wb_alu_out = alu; wb_mem_data = mem; wb_link_pc = link; wb_reg_write = we;
    endtask

    // Advance to just after the next rising edge, committing in the model
    task automatic tick();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = m_wen(); a = m_dest(); d = m_data();
        @(posedge clk);
        if (w) mdl[a] = d;
        #1;
    endtask

    task automatic dbg_check(input string name, input logic [4:0] a);
        dbg_addr = a;
        #1;
        check(name, dbg_data, mdl[a]);
        check({name, "_nb"}, nb_dbg_data, mdl[a]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  dst;
        logic [1:0]  m2r;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] link;
        logic        we;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b01, 2'b00, 5'd3,  5'd8,  32'h1234, 32'h9999, 32'h7777, 1'b1, 1'b1, 5'd8,  32'h1234};
        vecs[1] = '{2'b00, 2'b01, 5'd9,  5'd4,  32'h1111, 32'hCAFE, 32'h7777, 1'b1, 1'b1, 5'd9,  32'hCAFE};
        vecs[2] = '{2'b10, 2'b10, 5'd2,  5'd4,  32'h1111, 32'h2222, 32'h400008, 1'b1, 1'b1, 5'd31, 32'h400008};
        vecs[3] = '{2'b01, 2'b00, 5'd6,  5'd0,  32'hFFFF, 32'h2222, 32'h3333, 1'b1, 1'b0, 5'd0,  32'hFFFF};
        vecs[4] = '{2'b11, 2'b00, 5'd13, 5'd14, 32'hAAAA, 32'h2222, 32'h3333, 1'b1, 1'b0, 5'd0,  32'hAAAA};
        vecs[5] = '{2'b01, 2'b11, 5'd6,  5'd15, 32'hBEEF, 32'h1111, 32'h3333, 1'b1, 1'b1, 5'd15, 32'hBEEF};
        vecs[6] = '{2'b00, 2'b00, 5'd16, 5'd4,  32'h6666, 32'h1111, 32'h3333, 1'b0, 1'b0, 5'd0,  32'h6666};
        vecs[7] = '{2'b01, 2'b01, 5'd6,  5'd17, 32'h0101, 32'h5A5A, 32'h3333, 1'b1, 1'b1, 5'd17, 32'h5A5A};
    end

    // ---------------- main sequence ----------------
    initial begin
        clear_model();
        reset = 1'b0;
        ra1 = 5'd0; ra2 = 5'd0; dbg_addr = 5'd0;
        set_wb(2'b01, 2'b00, 5'd0, 5'd3, 32'h42, 32'h0, 32'h0, 1'b1);
        #2;
        check("reset_fwd_wen", {31'd0, fwd_wen}, 32'd0);
        check("reset_fwd_waddr", {27'd0, fwd_waddr}, 32'd0);
        ra1 = 5'd3;
        #1;
        check("reset_rd1", rd1, 32'd0);
        wb_reg_write = 1'b0;
        #9 reset = 1'b1;
        dbg_check("reset_dbg3", 5'd3);

        // Test 1: async reset clears without an edge
        @(posedge clk); #1;
        set_wb(2'b01, 2'b00, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1);
        tick();
        wb_reg_write = 1'b0;
        ra1 = 5'd5; ra2 = 5'd5;
        dbg_check("t1_pre_dbg5", 5'd5);
        #1 reset = 1'b0;
        clear_model();
        #1;
        check("t1_dbg5", dbg_data, 32'd0);
        check("t1_rd1", rd1, 32'd0);
        check("t1_rd2", rd2, 32'd0);
        #1 reset = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set_wb(vecs[i].dst, vecs[i].m2r, vecs[i].rt, vecs[i].rd,
                   vecs[i].alu, vecs[i].mem, vecs[i].link, vecs[i].we);
            #1;
            check($sformatf("vec%0d_wen", i), {31'd0, fwd_wen}, {31'd0, vecs[i].exp_wen});
            check($sformatf("vec%0d_waddr", i), {27'd0, fwd_waddr}, {27'd0, vecs[i].exp_waddr});
            check($sformatf("vec%0d_wdata", i), fwd_wdata, vecs[i].exp_wdata);
            tick();
            wb_reg_write = 1'b0;
            if (vecs[i].exp_wen) begin
                dbg_addr = vecs[i].exp_waddr;
                #1;
                check($sformatf("vec%0d_commit", i), dbg_data, vecs[i].exp_wdata);
            end else begin
                dbg_check($sformatf("vec%0d_rt_keep", i), vecs[i].rt);
                dbg_check($sformatf("vec%0d_rd_keep", i), vecs[i].rd);
            end
        end
        dbg_check("r0_zero", 5'd0);

        // Test 4: same-cycle bypass vs. no bypass
        @(posedge clk); #1;
        set_wb(2'b01, 2'b00, 5'd0, 5'd10, 32'h55, 32'h0, 32'h0, 1'b1);
        ra1 = 5'd10; ra2 = 5'd10;
        #1;
        check("t4_rd1_byp", rd1, 32'h55);
        check("t4_rd2_byp", rd2, 32'h55);
        check("t4_rd1_nobyp_old", nb_rd1, 32'd0);
        check("t4_rd2_nobyp_old", nb_rd2, 32'd0);
        tick();
        wb_reg_write = 1'b0;
        #1;
        check("t4_rd1_nobyp_new", nb_rd1, 32'h55);
        check("t4_rd1_after", rd1, 32'h55);

        // Bypass never applies to $0
        set_wb(2'b01, 2'b00, 5'd0, 5'd0, 32'hFFFF, 32'h0, 32'h0, 1'b1);
        ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("t5_rd1_r0", rd1, 32'd0);
        check("t5_rd2_r0", rd2, 32'd0);
        tick();
        wb_reg_write = 1'b0;

        // Test 6: reset asserted between edges discards the pending write
        @(posedge clk); #1;
        set_wb(2'b01, 2'b00, 5'd0, 5'd12, 32'h77, 32'h0, 32'h0, 1'b1);
        #1;
        check("t6_wen_pre", {31'd0, fwd_wen}, 32'd1);
        #1 reset = 1'b0;
        clear_model();
        #1;
        check("t6_wen_rst", {31'd0, fwd_wen}, 32'd0);
        tick();
        dbg_check("t6_dbg12", 5'd12);
        wb_reg_write = 1'b0;
        #1 reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            set_wb(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) != 0));
            ra1 = ($urandom_range(0, 1) != 0) ? m_dest() : 5'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom);
            dbg_addr = 5'($urandom);
            #1;
            check("rnd_wen", {31'd0, fwd_wen}, {31'd0, m_wen()});
            check("rnd_waddr", {27'd0, fwd_waddr}, m_wen() ? {27'd0, m_dest()} : 32'd0);
            check("rnd_wdata", fwd_wdata, m_data());
            check("rnd_rd1", rd1, m_read(ra1, 1'b1));
            check("rnd_rd2", rd2, m_read(ra2, 1'b1));
            check("rnd_nb_rd1", nb_rd1, m_read(ra1, 1'b0));
            check("rnd_nb_rd2", nb_rd2, m_read(ra2, 1'b0));
            check("rnd_dbg", dbg_data, (dbg_addr == 5'd0) ? 32'd0 : mdl[dbg_addr]);
            tick();
        end
        wb_reg_write = 1'b0;

        // Final sweep of the whole register file
        for (int i = 0; i < 32; i++) begin
            dbg_check($sformatf("sweep_r%0d", i), 5'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
